// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg : state codes and sizing shared by fifo_core_16 and its decoder
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int PTR_W = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT   = 3'b000;
  localparam state_t ST_NO_OP  = 3'b001;
  localparam state_t ST_WRITE  = 3'b010;
  localparam state_t ST_WR_ERR = 3'b011;
  localparam state_t ST_READ   = 3'b100;
  localparam state_t ST_RD_ERR = 3'b101;

endpackage

`default_nettype wire

// File: rtl/fifo_mem_16.sv
// ----------------------------------------------------------------------------
// fifo_mem_16 : 16 x DATA_W register file, one write port, one registered read
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_mem_16
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is intentionally left uninitialised; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_core_16.sv
// ----------------------------------------------------------------------------
// fifo_core_16 : 16-entry FIFO core driven by an external next-state decoder.
//                FIFO_ALMOST_FLAGS_EN adds registered almost_full/almost_empty.
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_core_16
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AF_TH  = 14,
  parameter int AE_TH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        next_state,
  input  logic [DATA_W-1:0] din,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  data_count,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam bit c_TH_OK = (AF_TH <= DEPTH) && (AE_TH >= 0) && (AE_TH < AF_TH);

  state_t             r_state;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_wr_ack, r_wr_err, r_rd_ack, r_rd_err;
  state_t             w_ns;
  logic               w_we;
  logic               w_re;
  logic [CNT_W-1:0]   w_count_nxt;

  // Unknown or unused codes collapse to NO_OP so nothing moves.
  always_comb begin
    w_ns = ST_NO_OP;
    case (next_state)
      ST_INIT, ST_NO_OP, ST_WRITE, ST_WR_ERR, ST_READ, ST_RD_ERR: w_ns = next_state;
      default: w_ns = ST_NO_OP;
    endcase
  end

  assign w_we        = !reset && (w_ns == ST_WRITE) && !full;
  assign w_re        = !reset && (w_ns == ST_READ) && !empty;
  assign w_count_nxt = r_count + CNT_W'(w_we) - CNT_W'(w_re);

  fifo_mem_16 #(.DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .waddr (r_tail),
    .wdata (din),
    .re    (w_re),
    .raddr (r_head),
    .rdata (dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_state  <= w_ns;
      r_count  <= w_count_nxt;
      r_wr_ack <= w_we;
      r_wr_err <= (w_ns == ST_WR_ERR);
      r_rd_ack <= w_re;
      r_rd_err <= (w_ns == ST_RD_ERR);
      if (w_we) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_re) begin
        r_head <= r_head + PTR_W'(1);
      end
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [CNT_W-1:0] c_AF = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] c_AE = CNT_W'(AE_TH);

  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_nxt >= c_AF);
      r_almost_empty <= (w_count_nxt <= c_AE);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

  // A well-behaved decoder never asks for a blocked move; flag it if it does.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (c_TH_OK);
      assert (!((w_ns == ST_WRITE) && full));
      assert (!((w_ns == ST_READ) && empty));
      assert (r_count <= CNT_W'(DEPTH));
    end
  end

  assign state      = r_state;
  assign data_count = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign wr_ack     = r_wr_ack;
  assign wr_err     = r_wr_err;
  assign rd_ack     = r_rd_ack;
  assign rd_err     = r_rd_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_core_16.sv
// ----------------------------------------------------------------------------
// tb_fifo_core_16 : directed + randomized bench for fifo_core_16 against a
//                   queue-based reference model
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_core_16;
  import fifo_pkg::*;

  localparam int DATA_W = 32;
  localparam int AF_TH  = 14;
  localparam int AE_TH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        next_state;
  logic [DATA_W-1:0] din;
  logic [2:0]        state;
  logic [CNT_W-1:0]  data_count;
  logic [DATA_W-1:0] dout;
  logic              full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic              almost_full, almost_empty;
`endif

  fifo_core_16 #(.DATA_W(DATA_W), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .clk        (clk),
    .reset      (reset),
    .next_state (next_state),
    .din        (din),
    .state      (state),
    .data_count (data_count),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus the last observed outputs.
  logic [DATA_W-1:0] m_q [$];
  logic [DATA_W-1:0] m_dout;
  logic [2:0]        m_state;
  logic [3:0]        m_hs;    // {wr_ack, wr_err, rd_ack, rd_err}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [2:0] ns, input logic [DATA_W-1:0] d);
    logic [2:0] eff;
    if (r) begin
      m_q.delete();
      m_dout  = '0;
      m_state = ST_INIT;
      m_hs    = 4'b0000;
    end else begin
      eff     = (ns > ST_RD_ERR) ? ST_NO_OP : ns;
      m_state = eff;
      m_hs    = {eff == ST_WRITE, eff == ST_WR_ERR, eff == ST_READ, eff == ST_RD_ERR};
      if (eff == ST_WRITE) m_q.push_back(d);
      if (eff == ST_READ)  m_dout = m_q.pop_front();
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":state"}, 64'(state), 64'(m_state));
    chk({ph, ":count"}, 64'(data_count), 64'(m_q.size()));
    chk({ph, ":full"},  64'(full),  64'(m_q.size() == DEPTH));
    chk({ph, ":empty"}, 64'(empty), 64'(m_q.size() == 0));
    chk({ph, ":dout"},  64'(dout),  64'(m_dout));
    chk({ph, ":hs"},    64'({wr_ack, wr_err, rd_ack, rd_err}), 64'(m_hs));
`ifdef FIFO_ALMOST_FLAGS_EN
    chk({ph, ":afull"},  64'(almost_full),  64'(m_q.size() >= AF_TH));
    chk({ph, ":aempty"}, 64'(almost_empty), 64'(m_q.size() <= AE_TH));
`endif
  endtask

  task automatic cycle(input string ph, input logic r, input logic [2:0] ns, input logic [DATA_W-1:0] d);
    reset      = r;
    next_state = ns;
    din        = d;
    @(posedge clk);
    model_edge(r, ns, d);
    @(negedge clk);
    check_all(ph);
  endtask

  // Decoder behaviour for a write and/or read request at the model's occupancy.
  function automatic logic [2:0] decode(input bit wr, input bit rd);
    if (wr && rd)  return ST_NO_OP;
    if (wr)        return (m_q.size() == DEPTH) ? ST_WR_ERR : ST_WRITE;
    if (rd)        return (m_q.size() == 0)     ? ST_RD_ERR : ST_READ;
    return ST_NO_OP;
  endfunction

  initial begin
    m_q.delete();
    m_dout  = '0;
    m_state = ST_INIT;
    m_hs    = 4'b0000;

    cycle("rst0", 1'b1, ST_WRITE, 32'hAAAA_AAAA);
    cycle("rst1", 1'b1, ST_WRITE, 32'hAAAA_AAAA);

    for (int i = 0; i < 16; i++) cycle("fill", 1'b0, ST_WRITE, DATA_W'(i));
    cycle("wr_err", 1'b0, ST_WR_ERR, 32'hDEAD_BEEF);
    cycle("full_hold", 1'b0, ST_NO_OP, 32'h0);

    for (int i = 0; i < 16; i++) cycle("drain", 1'b0, ST_READ, 32'h0);
    cycle("rd_err", 1'b0, ST_RD_ERR, 32'h0);

    for (int i = 0; i < 10; i++) cycle("wrap_w10", 1'b0, ST_WRITE, $urandom);
    for (int i = 0; i < 10; i++) cycle("wrap_r10", 1'b0, ST_READ, 32'h0);
    for (int i = 0; i < 12; i++) cycle("wrap_w12", 1'b0, ST_WRITE, $urandom);
    for (int i = 0; i < 12; i++) cycle("wrap_r12", 1'b0, ST_READ, 32'h0);

    for (int i = 0; i < 8; i++) cycle("pre7", 1'b0, ST_WRITE, $urandom);
    cycle("pre7_rd", 1'b0, ST_READ, 32'h0);
    cycle("noop7", 1'b0, decode(1'b1, 1'b1), 32'h1234_5678);
    cycle("ill111", 1'b0, 3'b111, 32'h1111_1111);
    cycle("ill110", 1'b0, 3'b110, 32'h2222_2222);
    cycle("init_ns", 1'b0, ST_INIT, 32'h3333_3333);

    cycle("to9a", 1'b0, ST_WRITE, $urandom);
    cycle("to9b", 1'b0, ST_WRITE, $urandom);
    cycle("rst_mid", 1'b1, ST_WRITE, 32'h5555_5555);
    cycle("rd_after_rst", 1'b0, decode(1'b0, 1'b1), 32'h0);

    for (int i = 0; i < 15; i++) cycle("af_up", 1'b0, ST_WRITE, $urandom);
    for (int i = 0; i < 15; i++) cycle("ae_dn", 1'b0, ST_READ, 32'h0);

    for (int i = 0; i < 400; i++) begin
      int  sel;
      bit  wr, rd;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        cycle("rnd_ill", 1'b0, 3'($urandom_range(6, 7)), $urandom);
      end else if (sel == 1) begin
        cycle("rnd_rst", 1'b1, 3'($urandom_range(0, 7)), $urandom);
      end else begin
        // Drift towards both ends so full/empty boundaries are exercised.
        wr = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 30));
        rd = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
        cycle("rnd", 1'b0, decode(wr, rd), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
